// File: rtl/seg_disp_src.sv
// ---------------------------------------------------------------------------
// seg_disp_src
//
// Display-source controller feeding the 8-digit seven-segment scanner.
// Selects what the scanner shows: the CPU PC, a stepped register-file word,
// a stepped data-memory word, or a graphic marquee test pattern. Stepping
// happens on a programmable auto-advance tick (can be paused) or on a
// debounced push-button press.
//
// Parameters:
//   STEP_DIV   clk cycles per auto-advance tick (>= 2)
//   DB_CYCLES  stable cycles required before the button level is accepted (>= 2)
//   DM_DEPTH   number of data-memory words stepped through (<= 64)
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   sw_src     source select switch (async): 00 PC, 01 regfile, 10 dmem, 11 pattern
//   sw_pause   pause switch (async): 1 inhibits auto-advance
//   btn_step   raw push-button (async), active-high
//   dbg_pc     current PC, synchronous to clk
//   rf_addr    register-file debug read address
//   rf_data    combinational register-file read data for rf_addr
//   dm_addr    data-memory debug read address
//   dm_data    combinational data-memory read data for dm_addr
//   disp_data  64-bit word to the display scanner
//   disp_mode  0 = hex-character mode (bits 31:0 meaningful), 1 = graphic mode
//
// There is no valid/ready handshake on this block: the scanner samples
// disp_data/disp_mode continuously, and the debug read ports are purely
// combinational address-in / data-out.
// ---------------------------------------------------------------------------
module seg_disp_src #(
    parameter int STEP_DIV  = 25_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int DM_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  sw_src,
    input  logic        sw_pause,
    input  logic        btn_step,
    input  logic [31:0] dbg_pc,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [5:0]  dm_addr,
    input  logic [31:0] dm_data,
    output logic [63:0] disp_data,
    output logic        disp_mode
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int TW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [5:0]    DM_LAST   = 6'(DM_DEPTH - 1);

    localparam logic [1:0] SRC_PC  = 2'b00;
    localparam logic [1:0] SRC_RF  = 2'b01;
    localparam logic [1:0] SRC_DM  = 2'b10;
    localparam logic [1:0] SRC_PAT = 2'b11;

    // -----------------------------------------------------------------------
    // Input synchronizers (2-FF each). Only the second stage is used below.
    // -----------------------------------------------------------------------
    logic [1:0] src_m;
    logic [1:0] src;
    logic       pause_m;
    logic       pause;
    logic       btn_m;
    logic       btn_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_m   <= SRC_PC;
            src     <= SRC_PC;
            pause_m <= 1'b0;
            pause   <= 1'b0;
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            src_m   <= sw_src;
            src     <= src_m;
            pause_m <= sw_pause;
            pause   <= pause_m;
            btn_m   <= btn_step;
            btn_s   <= btn_m;
        end
    end

    // -----------------------------------------------------------------------
    // Button debounce.
    // The counter runs only while the synchronized level disagrees with the
    // accepted level; any agreeing sample restarts it, so a glitch shorter
    // than DB_CYCLES never gets through. step is registered and fires on the
    // same edge that accepts a new high level, so it is a single-cycle pulse.
    // -----------------------------------------------------------------------
    logic [DW-1:0] db_cnt;
    logic          btn_db;
    logic          step;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
            step   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                    // Only a 0->1 acceptance is a press; release is silent.
                    step   <= btn_s;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Source tracking, tick and advance qualification.
    // src_q is the source the display and indices are currently working on.
    // A change of src is seen for exactly one cycle as src != src_q; in that
    // cycle the new source's index and the tick counter restart, and any
    // coincident advance is dropped so the new source always starts at 0.
    // -----------------------------------------------------------------------
    logic [1:0]    src_q;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          src_chg;
    logic          adv;

    assign tick    = (tick_cnt == TICK_LAST);
    assign src_chg = (src != src_q);
    // pause masks only the tick; the button is always honoured. tick and
    // step together still produce a single advance.
    assign adv     = ((tick & ~pause) | step) & ~src_chg;

    // -----------------------------------------------------------------------
    // Indices
    // -----------------------------------------------------------------------
    logic [4:0] rf_idx;
    logic [5:0] dm_idx;
    logic [2:0] phase;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q    <= SRC_PC;
            tick_cnt <= '0;
            rf_idx   <= '0;
            dm_idx   <= '0;
            phase    <= '0;
        end else begin
            src_q <= src;

            if (src_chg) begin
                // The tick counter keeps running while paused; it is only
                // restarted here so the first step of a new source lands a
                // full STEP_DIV period after the switch takes effect.
                tick_cnt <= '0;
                case (src)
                    SRC_RF:  rf_idx <= '0;
                    SRC_DM:  dm_idx <= '0;
                    SRC_PAT: phase  <= '0;
                    default: ;
                endcase
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            end

            // adv is already forced low during a source change.
            if (adv) begin
                case (src_q)
                    SRC_RF:  rf_idx <= rf_idx + 5'd1;
                    SRC_DM:  dm_idx <= (dm_idx == DM_LAST) ? 6'd0 : dm_idx + 6'd1;
                    SRC_PAT: phase  <= phase + 3'd1;
                    default: ;
                endcase
            end
        end
    end

    // Debug read addresses come straight from the index registers so the
    // read data is stable for a whole cycle before it is captured.
    assign rf_addr = rf_idx;
    assign dm_addr = dm_idx;

    // -----------------------------------------------------------------------
    // Display formatting
    // Character modes show two index digits followed by the low six data
    // digits. Pattern mode lights only segment g (active-low 8'hBF) on the
    // digit selected by phase and blanks the others.
    // -----------------------------------------------------------------------
    logic [63:0] fmt;

    always_comb begin
        fmt = '0;
        case (src_q)
            SRC_PC: begin
                fmt[31:0] = dbg_pc;
            end
            SRC_RF: begin
                fmt[31:0] = {3'b000, rf_idx, rf_data[23:0]};
            end
            SRC_DM: begin
                fmt[31:0] = {2'b00, dm_idx, dm_data[23:0]};
            end
            default: begin
                for (int b = 0; b < 8; b++) begin
                    fmt[b*8 +: 8] = (phase == 3'(b)) ? 8'hBF : 8'hFF;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_data <= '0;
            disp_mode <= 1'b0;
        end else begin
            disp_data <= fmt;
            disp_mode <= (src_q == SRC_PAT);
        end
    end

    // The top data bytes are not displayed in character mode.
    logic unused_bits;
    assign unused_bits = ^{rf_data[31:24], dm_data[31:24]};

endmodule

// File: tb/tb_seg_disp_src.sv
// ---------------------------------------------------------------------------
// tb_seg_disp_src
//
// Self-checking bench for seg_disp_src with small parameters
// (STEP_DIV=8, DB_CYCLES=4, DM_DEPTH=16). Expectations are computed from the
// externally visible timing: a source switch settles in three clock edges,
// after which the selected index equals floor(edges/STEP_DIV) modulo its
// range, and a button press counts when it stays high for DB_CYCLES cycles.
// ---------------------------------------------------------------------------
module tb_seg_disp_src;

    localparam int STEP_DIV  = 8;
    localparam int DB_CYCLES = 4;
    localparam int DM_DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  sw_src;
    logic        sw_pause;
    logic        btn_step;
    logic [31:0] dbg_pc;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [5:0]  dm_addr;
    logic [31:0] dm_data;
    logic [63:0] disp_data;
    logic        disp_mode;

    logic [31:0] dm_mem [64];

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT and memory models ----------------
    assign rf_data = 32'hA500_0000 + {27'd0, rf_addr};
    assign dm_data = dm_mem[dm_addr];

    seg_disp_src #(
        .STEP_DIV (STEP_DIV),
        .DB_CYCLES(DB_CYCLES),
        .DM_DEPTH (DM_DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sw_src   (sw_src),
        .sw_pause (sw_pause),
        .btn_step (btn_step),
        .dbg_pc   (dbg_pc),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .dm_addr  (dm_addr),
        .dm_data  (dm_data),
        .disp_data(disp_data),
        .disp_mode(disp_mode)
    );

    // ---------------- reference helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] exp_pattern(input int p);
        logic [63:0] ones;
        ones = '1;
        return ones ^ (64'h40 << (8 * p));
    endfunction

    function automatic logic [63:0] exp_rf(input int idx);
        logic [31:0] d;
        logic [4:0]  i5;
        d  = 32'hA500_0000 + idx;
        i5 = idx[4:0];
        return {32'd0, 3'b000, i5, d[23:0]};
    endfunction

    function automatic logic [63:0] exp_dm(input int idx);
        logic [31:0] d;
        logic [5:0]  i6;
        d  = dm_mem[idx];
        i6 = idx[5:0];
        return {32'd0, 2'b00, i6, d[23:0]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] pc;
        rstn = 1'b0; sw_src = 2'b00; sw_pause = 1'b0; btn_step = 1'b0;
        dbg_pc = 32'h0040_0010;
        cyc(3);
        checks++; if (disp_data !== 64'd0) begin errors++; $display("FAIL reset_disp_data got=%h exp=0", disp_data); end
        checks++; if (disp_mode !== 1'b0)  begin errors++; $display("FAIL reset_disp_mode got=%b exp=0", disp_mode); end
        checks++; if (rf_addr !== 5'd0)    begin errors++; $display("FAIL reset_rf_addr got=%0d exp=0", rf_addr); end
        checks++; if (dm_addr !== 6'd0)    begin errors++; $display("FAIL reset_dm_addr got=%0d exp=0", dm_addr); end
        rstn = 1'b1;
        cyc(2);
        checks++; if (disp_data !== 64'h0000_0000_0040_0010) begin errors++; $display("FAIL pc_after_reset got=%h exp=%h", disp_data, 64'h0000_0000_0040_0010); end
        checks++; if (disp_mode !== 1'b0) begin errors++; $display("FAIL pc_mode got=%b exp=0", disp_mode); end
        for (int k = 0; k < 4; k++) begin
            pc = $urandom;
            dbg_pc = pc;
            cyc(1);
            checks++; if (disp_data !== {32'd0, pc}) begin errors++; $display("FAIL pc_follow got=%h exp=%h", disp_data, {32'd0, pc}); end
        end
    endtask

    task automatic test_rf_auto;
        int e;
        int p;
        sw_src = 2'b01; sw_pause = 1'b0;
        cyc(3);
        checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL rf_start got=%0d exp=0", rf_addr); end
        for (int j = 1; j <= 32 * STEP_DIV + 16; j++) begin
            cyc(1);
            e = (j / STEP_DIV) % 32;
            p = ((j - 1) / STEP_DIV) % 32;
            checks++; if (rf_addr !== 5'(e)) begin errors++; $display("FAIL rf_step j=%0d got=%0d exp=%0d", j, rf_addr, e); end
            checks++; if (disp_data !== exp_rf(p)) begin errors++; $display("FAIL rf_disp j=%0d got=%h exp=%h", j, disp_data, exp_rf(p)); end
            if (p == 31) begin
                checks++; if (disp_data[31:0] !== 32'h1F00_001F) begin errors++; $display("FAIL rf_idx31_disp got=%h exp=1f00001f", disp_data[31:0]); end
            end
        end
    endtask

    task automatic test_pause_debounce;
        bit moved;
        bit found;
        int lat;
        sw_src = 2'b10; sw_pause = 1'b1; btn_step = 1'b0;
        cyc(3);
        checks++; if (dm_addr !== 6'd0) begin errors++; $display("FAIL dm_start got=%0d exp=0", dm_addr); end
        moved = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (dm_addr !== 6'd0) moved = 1'b1;
        end
        checks++; if (moved) begin errors++; $display("FAIL pause_hold got=moved exp=steady"); end
        checks++; if (disp_data !== exp_dm(0)) begin errors++; $display("FAIL dm_disp0 got=%h exp=%h", disp_data, exp_dm(0)); end
        for (int k = 0; k < 8; k++) begin
            btn_step = 1'b1;
            cyc($urandom_range(1, DB_CYCLES - 1));
            btn_step = 1'b0;
            cyc($urandom_range(1, 4));
        end
        cyc(10);
        checks++; if (dm_addr !== 6'd0) begin errors++; $display("FAIL bounce_ignored got=%0d exp=0", dm_addr); end
        btn_step = 1'b1;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            if (!found && dm_addr == 6'd1) begin found = 1'b1; lat = k; end
            if (k == 10) btn_step = 1'b0;
        end
        checks++; if (!found) begin errors++; $display("FAIL press_timeout got=no_advance exp=advance"); end
        checks++; if (lat != 2 + DB_CYCLES + 1) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", lat, 2 + DB_CYCLES + 1); end
        cyc(30);
        checks++; if (dm_addr !== 6'd1) begin errors++; $display("FAIL press_once got=%0d exp=1", dm_addr); end
        checks++; if (disp_data !== exp_dm(1)) begin errors++; $display("FAIL press_disp got=%h exp=%h", disp_data, exp_dm(1)); end
    endtask

    task automatic test_src_change;
        sw_src = 2'b00;
        cyc(4);
        sw_src = 2'b10; sw_pause = 1'b0;
        cyc(3);
        checks++; if (dm_addr !== 6'd0) begin errors++; $display("FAIL chg_dm_start got=%0d exp=0", dm_addr); end
        for (int j = 1; j <= 55; j++) begin
            cyc(1);
            if (j == 40) btn_step = 1'b1;
            if (j == 44) begin
                checks++; if (dm_addr !== 6'd5) begin errors++; $display("FAIL chg_dm5 got=%0d exp=5", dm_addr); end
                checks++; if (disp_data !== exp_dm(5)) begin errors++; $display("FAIL chg_dm5_disp got=%h exp=%h", disp_data, exp_dm(5)); end
                sw_src = 2'b01;
            end
            if (j == 47) begin
                checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL chg_rf_clear got=%0d exp=0", rf_addr); end
                checks++; if (dm_addr !== 6'd5) begin errors++; $display("FAIL chg_step_dropped got=%0d exp=5", dm_addr); end
            end
            if (j == 48) begin
                checks++; if (disp_data !== exp_rf(0)) begin errors++; $display("FAIL chg_rf_disp got=%h exp=%h", disp_data, exp_rf(0)); end
            end
            if (j == 50) btn_step = 1'b0;
            if (j == 54) begin
                checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL chg_tick_restart got=%0d exp=0", rf_addr); end
            end
            if (j == 55) begin
                checks++; if (rf_addr !== 5'd1) begin errors++; $display("FAIL chg_first_adv got=%0d exp=1", rf_addr); end
            end
        end
    endtask

    task automatic test_coincide;
        sw_src = 2'b10; sw_pause = 1'b0; btn_step = 1'b0;
        cyc(3);
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            if (j == 1) btn_step = 1'b1;
            if (j == 12) btn_step = 1'b0;
            if (j == 7) begin
                checks++; if (dm_addr !== 6'd0) begin errors++; $display("FAIL coin_before got=%0d exp=0", dm_addr); end
            end
            if (j == 8 || j == 15) begin
                checks++; if (dm_addr !== 6'd1) begin errors++; $display("FAIL coin_once j=%0d got=%0d exp=1", j, dm_addr); end
            end
            if (j == 16) begin
                checks++; if (dm_addr !== 6'd2) begin errors++; $display("FAIL coin_next got=%0d exp=2", dm_addr); end
            end
        end
    endtask

    task automatic test_pattern;
        int p;
        sw_src = 2'b11; sw_pause = 1'b0;
        cyc(3);
        for (int j = 1; j <= 9 * STEP_DIV; j++) begin
            cyc(1);
            p = ((j - 1) / STEP_DIV) % 8;
            checks++; if (disp_mode !== 1'b1) begin errors++; $display("FAIL pat_mode j=%0d got=%b exp=1", j, disp_mode); end
            checks++; if (disp_data !== exp_pattern(p)) begin errors++; $display("FAIL pat_data j=%0d got=%h exp=%h", j, disp_data, exp_pattern(p)); end
        end
    endtask

    task automatic test_dm_wrap;
        int e;
        int p;
        sw_src = 2'b10; sw_pause = 1'b0;
        cyc(3);
        checks++; if (dm_addr !== 6'd0) begin errors++; $display("FAIL wrap_start got=%0d exp=0", dm_addr); end
        for (int j = 1; j <= (DM_DEPTH + 1) * STEP_DIV; j++) begin
            cyc(1);
            e = (j / STEP_DIV) % DM_DEPTH;
            p = ((j - 1) / STEP_DIV) % DM_DEPTH;
            checks++; if (dm_addr !== 6'(e)) begin errors++; $display("FAIL wrap_addr j=%0d got=%0d exp=%0d", j, dm_addr, e); end
            checks++; if (disp_data !== exp_dm(p)) begin errors++; $display("FAIL wrap_disp j=%0d got=%h exp=%h", j, disp_data, exp_dm(p)); end
        end
    endtask

    task automatic test_random_buttons;
        int presses;
        int db;
        int lvl;
        int len;
        sw_src = 2'b01; sw_pause = 1'b1; btn_step = 1'b0;
        cyc(3);
        presses = 0;
        for (int r = 0; r < 3; r++) begin
            db = 0;
            for (int s = 0; s < 12; s++) begin
                lvl = (s % 2 == 0) ? 1 : 0;
                len = $urandom_range(1, 8);
                btn_step = lvl[0];
                cyc(len);
                // A level is accepted only if it persists DB_CYCLES cycles.
                if (lvl != db && len >= DB_CYCLES) begin
                    if (lvl == 1) presses++;
                    db = lvl;
                end
            end
            btn_step = 1'b0;
            cyc(12);
            checks++; if (rf_addr !== 5'(presses % 32)) begin errors++; $display("FAIL rand_press r=%0d got=%0d exp=%0d", r, rf_addr, presses % 32); end
        end
    endtask

    task automatic test_reset_mid;
        sw_src = 2'b11; sw_pause = 1'b0;
        cyc(6);
        btn_step = 1'b1;
        cyc(2);
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (disp_data !== 64'd0) begin errors++; $display("FAIL mid_reset_disp got=%h exp=0", disp_data); end
        checks++; if (disp_mode !== 1'b0)  begin errors++; $display("FAIL mid_reset_mode got=%b exp=0", disp_mode); end
        checks++; if (rf_addr !== 5'd0)    begin errors++; $display("FAIL mid_reset_rf got=%0d exp=0", rf_addr); end
        checks++; if (dm_addr !== 6'd0)    begin errors++; $display("FAIL mid_reset_dm got=%0d exp=0", dm_addr); end
        sw_src = 2'b00; btn_step = 1'b0; dbg_pc = 32'hDEAD_BEEF;
        @(negedge clk);
        cyc(1);
        rstn = 1'b1;
        cyc(2);
        checks++; if (disp_data !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL post_reset_pc got=%h exp=%h", disp_data, 64'h0000_0000_DEAD_BEEF); end
        checks++; if (disp_mode !== 1'b0) begin errors++; $display("FAIL post_reset_mode got=%b exp=0", disp_mode); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 64; i++) dm_mem[i] = $urandom;
        test_reset;
        test_rf_auto;
        test_pause_debounce;
        test_src_change;
        test_coincide;
        test_pattern;
        test_dm_wrap;
        test_random_buttons;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
